// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: register index, FSM state
// and the in-flight load record.
package hazard_controller_pkg;

  typedef logic [4:0] reg_idx;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic   valid;
    reg_idx rd;
  } load_entry_t;

  localparam int CNT_W = 3;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic src_matches(input reg_idx src, input logic used, input reg_idx rd);
    return used && (src != '0) && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_controller_load_tracker.sv
// Tracks loads from execute onward and flags decode sources that depend on a
// load whose data is not yet forwardable.
module load_tracker
  import hazard_controller_pkg::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   advance,
  input  logic   push_valid,
  input  reg_idx push_rd,
  input  reg_idx id_rs1,
  input  reg_idx id_rs2,
  input  logic   id_uses_rs1,
  input  logic   id_uses_rs2,
  output logic   hazard
);

  load_entry_t ent_q [LOAD_LAT+1];
  load_entry_t ent_d [LOAD_LAT+1];

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch can be inferred on a path that skips an assignment.
  always_comb begin
    ent_d = ent_q;
    if (advance) begin
      ent_d[0] = '{valid: push_valid, rd: push_rd};
      for (int i = 1; i <= LOAD_LAT; i++) begin
        ent_d[i] = ent_q[i-1];
      end
    end
  end

  // NOTE: this is a handful of control flops, not a RAM, so every entry is
  // cleared on reset; a true memory array would be left unreset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= LOAD_LAT; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

  // The oldest entry has reached the forwarding point and no longer interlocks.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (ent_q[i].valid &&
          (src_matches(id_rs1, id_uses_rs1, ent_q[i].rd) ||
           src_matches(id_rs2, id_uses_rs2, ent_q[i].rd))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: global freeze, wrong-path squash after a
// redirect, and load-use interlock for fetch, decode and execute.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_LAT     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_busy,
  input  logic       jump,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_is_load,
  input  logic [4:0] id_rd,
  output logic       stall,
  output logic       hold_front,
  output logic       bubble,
  output logic       flush_front,
  output logic [1:0] state
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;
  logic             hazard_raw;
  logic             hazard;
  logic             push_valid;

  assign advance = ~mem_busy;
  assign hazard  = id_valid & hazard_raw;
  assign state   = {1'b0, state_q};

  // Priority: reset > stall > flush > hazard.
  always_comb begin
    stall       = 1'b0;
    hold_front  = 1'b0;
    bubble      = 1'b0;
    flush_front = 1'b0;
    if (reset) begin
      bubble      = 1'b1;
      flush_front = 1'b1;
    end else if (mem_busy) begin
      stall = 1'b1;
    end else if (jump || state_q == FLUSH) begin
      bubble      = 1'b1;
      flush_front = 1'b1;
    end else begin
      hold_front = hazard;
      bubble     = hazard;
    end
  end

  // A held or squashed decode slot must not enter the tracker as a load.
  assign push_valid = id_valid & id_is_load & (id_rd != '0) & ~hold_front & ~flush_front;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (advance) begin
      if (jump) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else if (state_q == FLUSH) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = RUN;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  load_tracker #(
    .LOAD_LAT(LOAD_LAT)
  ) u_load_tracker (
    .clock       (clock),
    .reset       (reset),
    .advance     (advance),
    .push_valid  (push_valid),
    .push_rd     (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard_raw)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller with default parameters
// (FLUSH_CYCLES = 2, LOAD_LAT = 2).
module tb_hazard_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_busy = 1'b0;
  logic       jump = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic       id_is_load = 1'b0;
  logic [4:0] id_rd = '0;
  logic       stall;
  logic       hold_front;
  logic       bubble;
  logic       flush_front;
  logic [1:0] state;

  always #5 clock = ~clock;

  hazard_controller dut (
    .clock       (clock),
    .reset       (reset),
    .mem_busy    (mem_busy),
    .jump        (jump),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_is_load  (id_is_load),
    .id_rd       (id_rd),
    .stall       (stall),
    .hold_front  (hold_front),
    .bubble      (bubble),
    .flush_front (flush_front),
    .state       (state)
  );

  typedef struct {
    logic       mb;
    logic       jmp;
    logic       iv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ld;
    logic [4:0] rd;
    logic       e_stall;
    logic       e_hold;
    logic       e_bub;
    logic       e_flush;
    logic [1:0] e_st;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int mb, jmp, iv, rs1, rs2, u1, u2, ld, rd,
                              input int es, eh, eb, ef, est);
    vec_t v;
    v.mb = 1'(mb);   v.jmp = 1'(jmp); v.iv = 1'(iv);
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1 = 1'(u1);   v.u2 = 1'(u2);   v.ld = 1'(ld); v.rd = 5'(rd);
    v.e_stall = 1'(es); v.e_hold = 1'(eh); v.e_bub = 1'(eb); v.e_flush = 1'(ef);
    v.e_st = 2'(est);
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_busy    = v.mb;
    jump        = v.jmp;
    id_valid    = v.iv;
    id_rs1      = v.rs1;
    id_rs2      = v.rs2;
    id_uses_rs1 = v.u1;
    id_uses_rs2 = v.u2;
    id_is_load  = v.ld;
    id_rd       = v.rd;
    exp_q.push_back(v);
  endtask

  task automatic sample(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".stall"},       {1'b0, stall},       {1'b0, e.e_stall});
      check({tag, ".hold_front"},  {1'b0, hold_front},  {1'b0, e.e_hold});
      check({tag, ".bubble"},      {1'b0, bubble},      {1'b0, e.e_bub});
      check({tag, ".flush_front"}, {1'b0, flush_front}, {1'b0, e.e_flush});
      check({tag, ".state"},       state,               e.e_st);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    @(negedge clock);
    sample(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    mem_busy = 1'b0; jump = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_is_load = 1'b0; id_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mb j iv rs1 rs2 u1 u2 ld rd   st ho bu fl s
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0)); // idle
    tbl.push_back(mk(0,1,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0)); // jump
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1)); // flush cycle 2
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 5,   0, 0, 0, 0, 0)); // load x5
    tbl.push_back(mk(0,0,1, 5, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0)); // dep: bubble 1
    tbl.push_back(mk(0,0,1, 5, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0)); // bubble 2
    tbl.push_back(mk(0,0,1, 5, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0)); // released
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0)); // load x0
    tbl.push_back(mk(0,0,1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0)); // reads x0
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 5,   0, 0, 0, 0, 0)); // load x5
    tbl.push_back(mk(0,0,1, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0)); // rs1 unused
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 7,   0, 0, 0, 0, 0)); // load x7
    tbl.push_back(mk(0,0,1, 0, 7, 0, 1, 0, 0,   0, 1, 1, 0, 0)); // dep on rs2
    tbl.push_back(mk(0,0,1, 0, 7, 0, 1, 0, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 7, 0, 1, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 9,   0, 0, 0, 0, 0)); // load x9
    tbl.push_back(mk(0,0,1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0)); // independent
    tbl.push_back(mk(0,0,1, 9, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0)); // one slot later: 1 bubble
    tbl.push_back(mk(0,0,1, 9, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 5,   0, 0, 0, 0, 0)); // load x5
    tbl.push_back(mk(1,0,1, 5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0)); // stall x3
    tbl.push_back(mk(1,0,1, 5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(1,0,1, 5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 5, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0)); // full 2 bubbles after
    tbl.push_back(mk(0,0,1, 5, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 5, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1,1,0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0)); // jump under stall
    tbl.push_back(mk(1,1,0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0)); // acted on now
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0)); // load x3
    tbl.push_back(mk(0,1,1, 3, 0, 1, 0, 0, 0,   0, 0, 1, 1, 0)); // jump + hazard
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0)); // jump
    tbl.push_back(mk(1,0,0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1)); // stall inside FLUSH
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,1, 0, 0, 0, 0, 1, 4,   0, 0, 1, 1, 0)); // squashed load x4
    tbl.push_back(mk(0,0,1, 4, 0, 1, 0, 0, 0,   0, 0, 1, 1, 1));
    tbl.push_back(mk(0,0,1, 4, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0)); // no interlock
    tbl.push_back(mk(0,0,1, 0, 0, 0, 0, 1, 6,   0, 0, 0, 0, 0)); // load x6
    tbl.push_back(mk(0,0,1, 6, 0, 1, 0, 1, 8,   0, 1, 1, 0, 0)); // dependent load x8
    tbl.push_back(mk(0,0,1, 6, 0, 1, 0, 1, 8,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 6, 0, 1, 0, 1, 8,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,1, 8, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 8, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0,0,1, 8, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0));

    // Reset pulse with a valid instruction in decode.
    id_valid = 1'b1; id_is_load = 1'b1; id_rd = 5'd5;
    #2;
    check("rst.bubble",      {1'b0, bubble},      2'd1);
    check("rst.flush_front", {1'b0, flush_front}, 2'd1);
    check("rst.stall",       {1'b0, stall},       2'd0);
    check("rst.hold_front",  {1'b0, hold_front},  2'd0);
    @(negedge clock);
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    reset = 1'b0;
    #1;
    check("post_rst.state",      state,              2'd0);
    check("post_rst.hold_front", {1'b0, hold_front}, 2'd0);
    check("post_rst.bubble",     {1'b0, bubble},     2'd0);
    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset arriving in the middle of FLUSH.
    step(mk(0,1,0, 0,0,0,0,0,0, 0,0,1,1,0), "rf_jump");
    clear_inputs();
    #2;
    reset = 1'b1;
    #1;
    check("rf.state_in_reset", state, 2'd0);
    check("rf.flush_in_reset", {1'b0, flush_front}, 2'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(mk(0,0,0, 0,0,0,0,0,0, 0,0,0,0,0), "rf_after");

    // Reset during a stall clears the load tracker.
    step(mk(0,0,1, 0,0,0,0,1,5, 0,0,0,0,0), "rs_load");
    step(mk(1,0,1, 5,0,1,0,0,0, 1,0,0,0,0), "rs_stall");
    #2;
    reset = 1'b1;
    #1;
    check("rs.stall_in_reset",  {1'b0, stall},  2'd0);
    check("rs.bubble_in_reset", {1'b0, bubble}, 2'd1);
    @(negedge clock);
    mem_busy = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(mk(0,0,1, 5,0,1,0,0,0, 0,0,0,0,0), "rs_after");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
